// File: rtl/avmm_fill_check_master_pkg.sv
// Shared definitions for the Avalon-MM fill/check master.
//   op encodings, FSM state type, pattern modes, error counter width.
package avmm_fill_check_master_pkg;

    localparam logic [1:0] OP_FILL       = 2'b00;
    localparam logic [1:0] OP_CHECK      = 2'b01;
    localparam logic [1:0] OP_FILL_CHECK = 2'b10;

    localparam logic PAT_CONST = 1'b0;
    localparam logic PAT_INC   = 1'b1;

    localparam int ERR_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_FINISH
    } state_t;

endpackage

// File: rtl/avmm_fill_check_master_pattern_gen.sv
// Combinational pattern word generator.
//   seed, pat_mode, index -> word
//   word = seed (PAT_CONST) or seed + index mod 2^DATA_W (PAT_INC).
module avmm_pattern_gen
    import avmm_fill_check_master_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 9
) (
    input  logic [DATA_W-1:0] seed,
    input  logic              pat_mode,
    input  logic [IDX_W-1:0]  index,
    output logic [DATA_W-1:0] word
);

    assign word = (pat_mode == PAT_INC) ? seed + DATA_W'(index) : seed;

endmodule

// File: rtl/avmm_fill_check_master.sv
// Avalon-MM master that fills a word range of a RAM slave with a pattern,
// then (optionally) reads it back and counts mismatches.
//   clk/reset           : clock, synchronous active-high reset
//   start/op/pat_mode/base_addr/length/seed : command, latched in IDLE
//   busy/done/err_count/first_err_addr/error : status
//   avm_*               : Avalon-MM master port
module avmm_fill_check_master
    import avmm_fill_check_master_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int MAX_PENDING = 4,
    parameter int LEN_W       = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic                  pat_mode,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [LEN_W-1:0]      length,
    input  logic [DATA_W-1:0]     seed,
    output logic                  busy,
    output logic                  done,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0]     first_err_addr,
    output logic                  error,
    output logic [ADDR_W-1:0]     avm_address,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    output logic                  avm_chipselect,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [DATA_W-1:0]     avm_writedata,
    input  logic                  avm_waitrequest,
    input  logic [DATA_W-1:0]     avm_readdata,
    input  logic                  avm_readdatavalid
);

    localparam int PEND_W = $clog2(MAX_PENDING) + 1;

    state_t             state;
    logic [1:0]         op_q;
    logic               pat_q;
    logic [ADDR_W-1:0]  base_q;
    logic [LEN_W-1:0]   len_q;
    logic [DATA_W-1:0]  seed_q;
    logic [LEN_W-1:0]   wr_idx, rd_idx, rsp_idx;
    logic [PEND_W-1:0]  pending;
    logic [ERR_CNT_W-1:0] err_q;

    logic               wr_fire, rd_fire, rsp_fire;
    logic [LEN_W-1:0]   rd_idx_nxt;
    logic [PEND_W-1:0]  pend_nxt;
    logic [DATA_W-1:0]  wr_word, exp_word;

    assign wr_fire  = avm_write & ~avm_waitrequest;
    assign rd_fire  = avm_read  & ~avm_waitrequest;
    // Beats outside READ/DRAIN are leftovers from an aborted run.
    assign rsp_fire = avm_readdatavalid & ((state == ST_READ) | (state == ST_DRAIN));

    assign rd_idx_nxt = rd_idx + LEN_W'(rd_fire);
    assign pend_nxt   = pending + PEND_W'(rd_fire) - PEND_W'(rsp_fire);

    avmm_pattern_gen #(.DATA_W(DATA_W), .IDX_W(LEN_W)) u_wr_pat (
        .seed(seed_q), .pat_mode(pat_q), .index(wr_idx), .word(wr_word)
    );

    avmm_pattern_gen #(.DATA_W(DATA_W), .IDX_W(LEN_W)) u_exp_pat (
        .seed(seed_q), .pat_mode(pat_q), .index(rsp_idx), .word(exp_word)
    );

    // Address/data come straight from registered indices, so they hold
    // steady for as long as waitrequest stalls a beat.
    assign avm_address    = base_q + ADDR_W'((state == ST_READ) ? rd_idx : wr_idx);
    assign avm_writedata  = wr_word;
    assign avm_byteenable = '1;
    assign avm_chipselect = avm_read | avm_write;
    assign err_count      = err_q;
    assign error          = (err_q != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            op_q           <= OP_FILL;
            pat_q          <= PAT_CONST;
            base_q         <= '0;
            len_q          <= '0;
            seed_q         <= '0;
            wr_idx         <= '0;
            rd_idx         <= '0;
            rsp_idx        <= '0;
            pending        <= '0;
            err_q          <= '0;
            first_err_addr <= '0;
        end else begin
            done    <= 1'b0;
            pending <= pend_nxt;

            if (rsp_fire) begin
                rsp_idx <= rsp_idx + LEN_W'(1);
                if (avm_readdata != exp_word) begin
                    if (err_q != '1)
                        err_q <= err_q + ERR_CNT_W'(1);
                    if (err_q == '0)
                        first_err_addr <= base_q + ADDR_W'(rsp_idx);
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q           <= (op == OP_CHECK || op == OP_FILL_CHECK) ? op : OP_FILL;
                        pat_q          <= pat_mode;
                        base_q         <= base_addr;
                        len_q          <= length;
                        seed_q         <= seed;
                        wr_idx         <= '0;
                        rd_idx         <= '0;
                        rsp_idx        <= '0;
                        pending        <= '0;
                        err_q          <= '0;
                        first_err_addr <= '0;
                        busy           <= 1'b1;
                        if (length == '0) begin
                            state <= ST_FINISH;
                        end else if (op == OP_CHECK) begin
                            state    <= ST_READ;
                            avm_read <= 1'b1;
                        end else begin
                            state     <= ST_WRITE;
                            avm_write <= 1'b1;
                        end
                    end
                end

                ST_WRITE: begin
                    if (wr_fire) begin
                        wr_idx <= wr_idx + LEN_W'(1);
                        if (wr_idx + LEN_W'(1) == len_q) begin
                            avm_write <= 1'b0;
                            if (op_q == OP_FILL_CHECK) begin
                                // First read goes out on the very next cycle.
                                state    <= ST_READ;
                                avm_read <= 1'b1;
                            end else begin
                                state <= ST_FINISH;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end
                        end
                    end
                end

                ST_READ: begin
                    rd_idx <= rd_idx_nxt;
                    if (rd_idx_nxt == len_q) begin
                        avm_read <= 1'b0;
                        state    <= ST_DRAIN;
                    end else begin
                        // A stalled read never drops: pending cannot grow while stalled.
                        avm_read <= (pend_nxt < PEND_W'(MAX_PENDING));
                    end
                end

                ST_DRAIN: begin
                    if (pending == '0 && rsp_idx == len_q) begin
                        state <= ST_FINISH;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end

                ST_FINISH: begin
                    // Arriving with busy still set means a zero-length run:
                    // spend this cycle raising done, then return to IDLE.
                    if (busy) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
